boot_copy_dma: RTL and testbench

Boot-time copy engine that sits directly downstream of the boot ROM MMIO slave on the shared 32-bit valid/ready memory bus. Out of reset it holds the CPU and reads a fixed block of words from boot ROM at SRC_ADDR. It writes each word to RAM at DST_ADDR, keeps a running additive checksum, then releases the CPU. It is the bus master for this transfer and owns the bus while `cpu_hold` is high.

---
 rtl/boot_copy_dma.sv | 208 ++++++++++++++++++++
 tb/tb_boot_copy_dma.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_copy_dma.sv
// rtl/boot_copy_dma.sv - boot-time ROM-to-RAM copy engine with additive checksum
//
// Out of reset (or on a start pulse) this block owns the shared 32-bit
// valid/ready memory bus. It reads COPY_WORDS words from the boot ROM at
// SRC_ADDR, writes each one to RAM at DST_ADDR, and keeps a running sum of
// the copied words. The CPU is held in stall until the copy has finished
// and, when CHECK_EN is set, the image sums to zero.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       one-cycle pulse; starts a copy from IDLE, DONE or ERR
//   m_valid     bus request
//   m_instr     instruction-fetch flag, always 0 (data access)
//   m_ready     slave completion
//   m_addr      bus address (word aligned)
//   m_wdata     write data
//   m_wstrb     byte strobes: 0000 read, 1111 write
//   m_rdata     read data, valid while m_ready is high
//   busy        copy in progress
//   done        copy completed, held until next start or reset
//   error       copy aborted, held until next start or reset
//   err_code    00 none, 01 timeout, 10 checksum mismatch
//   cpu_hold    CPU stall request
//   checksum    running sum of copied words, modulo 2^32
//   words_done  number of words fully written

module boot_copy_dma #(
  parameter logic [31:0] SRC_ADDR   = 32'h2000_0000,
  parameter logic [31:0] DST_ADDR   = 32'h0000_0000,
  parameter int          COPY_WORDS = 256,
  parameter int          TIMEOUT    = 255,
  parameter bit          AUTO_START = 1'b1,
  parameter bit          CHECK_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        m_valid,
  output logic        m_instr,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        cpu_hold,
  output logic [31:0] checksum,
  output logic [15:0] words_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RD_GAP = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_WR_GAP = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [15:0] LAST_IDX = 16'(COPY_WORDS - 1);
  // The wait counter is compared one step early so the request is dropped
  // in the cycle the count reaches TIMEOUT, not one cycle later.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_SUM     = 2'b10;

  logic [2:0]  state;
  logic [15:0] idx;
  logic [15:0] tcount;
  logic [31:0] data_reg;
  logic        auto_pend;
  logic        sum_ok;
  logic        launch;
  logic [31:0] src_byte;
  logic [31:0] dst_byte;

  // Image is accepted when checking is off or the words sum to zero.
  assign sum_ok = (CHECK_EN == 1'b0) || (checksum == 32'd0);

  // A new copy may begin from any resting state; start is ignored while busy.
  always_comb begin
    launch = 1'b0;
    case (state)
      S_IDLE:  launch = start || auto_pend;
      S_DONE:  launch = start && sum_ok;
      S_ERR:   launch = start;
      default: launch = 1'b0;
    endcase
  end

  // Byte addresses wrap modulo 2^32; the low two bits are forced to zero.
  assign src_byte = SRC_ADDR + {14'd0, idx, 2'b00};
  assign dst_byte = DST_ADDR + {14'd0, idx, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 16'd0;
      tcount     <= 16'd0;
      data_reg   <= 32'd0;
      checksum   <= 32'd0;
      words_done <= 16'd0;
      err_code   <= ERR_NONE;
      auto_pend  <= AUTO_START;
    end else if (launch) begin
      state      <= S_RD;
      idx        <= 16'd0;
      tcount     <= 16'd0;
      checksum   <= 32'd0;
      words_done <= 16'd0;
      err_code   <= ERR_NONE;
      auto_pend  <= 1'b0;
    end else begin
      case (state)
        S_RD: begin
          if (m_ready) begin
            data_reg <= m_rdata;
            checksum <= checksum + m_rdata;
            state    <= S_RD_GAP;
          end else if (tcount == TO_LAST) begin
            state    <= S_ERR;
            err_code <= ERR_TIMEOUT;
          end else begin
            tcount <= tcount + 16'd1;
          end
        end

        // The slave registers ready from valid, so it may still be high here;
        // the valid-low gap keeps that stale ready from completing the write.
        S_RD_GAP: begin
          tcount <= 16'd0;
          state  <= S_WR;
        end

        S_WR: begin
          if (m_ready) begin
            words_done <= words_done + 16'd1;
            state      <= (idx == LAST_IDX) ? S_DONE : S_WR_GAP;
          end else if (tcount == TO_LAST) begin
            state    <= S_ERR;
            err_code <= ERR_TIMEOUT;
          end else begin
            tcount <= tcount + 16'd1;
          end
        end

        S_WR_GAP: begin
          idx    <= idx + 16'd1;
          tcount <= 16'd0;
          state  <= S_RD;
        end

        // Checksum verdict is taken on the first DONE cycle.
        S_DONE: begin
          if (!sum_ok) begin
            state    <= S_ERR;
            err_code <= ERR_SUM;
          end
        end

        S_IDLE, S_ERR: begin
          state <= state;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus and status outputs are decoded from registered state only, so there
  // is no combinational path from bus inputs to bus outputs.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_wstrb = 4'b0000;
    case (state)
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = {src_byte[31:2], 2'b00};
      end
      S_WR: begin
        m_valid = 1'b1;
        m_addr  = {dst_byte[31:2], 2'b00};
        m_wdata = data_reg;
        m_wstrb = 4'b1111;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  assign m_instr  = 1'b0;
  assign busy     = (state == S_RD) || (state == S_RD_GAP) ||
                    (state == S_WR) || (state == S_WR_GAP);
  assign done     = (state == S_DONE) && sum_ok;
  assign error    = (state == S_ERR);
  assign cpu_hold = !done;

endmodule

// File: tb/tb_boot_copy_dma.sv
// tb/tb_boot_copy_dma.sv - self-checking bench for boot_copy_dma
//
// Drives the engine against a behavioural memory slave (ROM image plus
// write log) and compares bus traffic, status and timing with a reference
// model computed from the copy rules.

module tb_boot_copy_dma;

  localparam logic [31:0] SRC = 32'h2000_0000;
  localparam logic [31:0] DST = 32'h0000_0000;
  localparam int          N   = 4;
  localparam int          TO  = 8;
  localparam int          LIMIT = 2000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        m_valid;
  logic        m_instr;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic        cpu_hold;
  logic [31:0] checksum;
  logic [15:0] words_done;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  bit          hold_mode = 1'b0;
  logic [31:0] rom [N];
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  boot_copy_dma #(
    .SRC_ADDR(SRC), .DST_ADDR(DST), .COPY_WORDS(N), .TIMEOUT(TO),
    .AUTO_START(1'b1), .CHECK_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .m_valid(m_valid), .m_instr(m_instr), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .cpu_hold(cpu_hold), .checksum(checksum), .words_done(words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: ready rises after valid has been held for lat cycles and
  // stays high while valid is held; in hold mode it also lingers through
  // the following valid-low cycle. Completed transfers are logged.
  initial begin
    int          vcnt;
    bit          prev_valid;
    bit          rdy;
    logic [31:0] off;
    vcnt = 0;
    prev_valid = 1'b0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (m_valid && !reset) vcnt++;
      else vcnt = 0;
      if (m_valid && !reset) rdy = (vcnt > lat);
      else rdy = hold_mode && m_ready && prev_valid && !reset;
      m_ready = rdy;
      m_rdata = $urandom;
      if (m_valid && rdy && !reset) begin
        if (m_wstrb == 4'b1111) begin
          wa_q.push_back(m_addr);
          wd_q.push_back(m_wdata);
        end else begin
          off = m_addr - SRC;
          rd_q.push_back(m_addr);
          m_rdata = (off < 32'(4 * N)) ? rom[off[3:2]] : 32'hDEAD_BEEF;
        end
      end
      prev_valid = m_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_m_valid"}, 32'(m_valid), 0);
    chk({p, "_m_instr"}, 32'(m_instr), 0);
    chk({p, "_m_addr"}, m_addr, 0);
    chk({p, "_m_wdata"}, m_wdata, 0);
    chk({p, "_m_wstrb"}, 32'(m_wstrb), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_error"}, 32'(error), 0);
    chk({p, "_err_code"}, 32'(err_code), 0);
    chk({p, "_cpu_hold"}, 32'(cpu_hold), 1);
    chk({p, "_checksum"}, checksum, 0);
    chk({p, "_words_done"}, 32'(words_done), 0);
  endtask

  // Called at the negedge of a resting cycle; returns in the first RD cycle.
  task automatic pulse_start(input string p);
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({p, "_first_rd_valid"}, 32'(m_valid), 1);
    chk({p, "_first_rd_addr"}, m_addr, SRC);
    chk({p, "_first_rd_done_clear"}, 32'(done), 0);
  endtask

  // From the first RD cycle, run until done or error; optionally pulse start
  // for one cycle at offset sp to show it is ignored while busy.
  task automatic run_to_end(input string p, input int sp, output int t);
    t = 0;
    while (!(done || error) && t < LIMIT) begin
      start = (t == sp);
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk({p, "_finished"}, 32'(done || error), 1);
  endtask

  // Reference: the image sums to S; accepted iff S==0; each word costs
  // (lat+1) read cycles, a gap, (lat+1) write cycles and a gap, less the
  // final gap; a checksum rejection costs one more cycle.
  task automatic verify(input string p, input int t);
    logic [31:0] s;
    bit          ok;
    int          base;
    s = 32'd0;
    for (int i = 0; i < N; i++) s += rom[i];
    ok = (s == 32'd0);
    base = N * (2 * lat + 4) - 1;
    chk({p, "_cycles"}, 32'(t), ok ? 32'(base) : 32'(base + 1));
    chk({p, "_done"}, 32'(done), 32'(ok));
    chk({p, "_error"}, 32'(error), 32'(!ok));
    chk({p, "_err_code"}, 32'(err_code), ok ? 32'd0 : 32'd2);
    chk({p, "_cpu_hold"}, 32'(cpu_hold), 32'(!ok));
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_checksum"}, checksum, s);
    chk({p, "_words_done"}, 32'(words_done), N);
    chk({p, "_nreads"}, rd_q.size(), N);
    chk({p, "_nwrites"}, wa_q.size(), N);
    for (int i = 0; i < N; i++) begin
      if (i < rd_q.size()) chk($sformatf("%s_rd_addr%0d", p, i), rd_q[i], SRC + 32'(4 * i));
      if (i < wa_q.size()) begin
        chk($sformatf("%s_wr_addr%0d", p, i), wa_q[i], DST + 32'(4 * i));
        chk($sformatf("%s_wr_data%0d", p, i), wd_q[i], rom[i]);
      end
    end
  endtask

  task automatic load_rom(input bit zero_sum);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < N; i++) begin
      rom[i] = $urandom;
      if (i < N - 1) s += rom[i];
    end
    if (zero_sum) rom[N - 1] = -s;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    lat = 1;
    hold_mode = 1'b0;
    load_rom(1'b1);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Auto start after reset release
    clear_logs();
    reset = 1'b0;
    t = 0;
    while (!m_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("auto_first_rd_delay", 32'(t), 1);
    chk("auto_first_rd_addr", m_addr, SRC);
    chk("auto_first_rd_wstrb", 32'(m_wstrb), 0);
    run_to_end("auto", -1, t);
    verify("auto", t);

    // Directed image summing to zero, restart from DONE
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'hFFFF_FFFA;
    pulse_start("sum0");
    run_to_end("sum0", -1, t);
    verify("sum0", t);

    // Checksum mismatch
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    pulse_start("bad");
    run_to_end("bad", -1, t);
    verify("bad", t);

    // Timeout on the first read
    lat = 100000;
    pulse_start("tmo");
    t = 0;
    while (m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_valid_cycles", 32'(t), TO);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_err_code", 32'(err_code), 1);
    chk("tmo_cpu_hold", 32'(cpu_hold), 1);
    chk("tmo_done", 32'(done), 0);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_words_done", 32'(words_done), 0);

    // Recovery from ERR with a working slave
    lat = 1;
    load_rom(1'b1);
    pulse_start("recover");
    run_to_end("recover", -1, t);
    verify("recover", t);

    // Ready held through the gap cycle
    hold_mode = 1'b1;
    for (int l = 1; l <= 2; l++) begin
      lat = l;
      load_rom(1'b1);
      pulse_start($sformatf("hold%0d", l));
      run_to_end($sformatf("hold%0d", l), -1, t);
      verify($sformatf("hold%0d", l), t);
    end
    hold_mode = 1'b0;
    lat = 1;

    // Start pulsed while busy is ignored
    load_rom(1'b1);
    pulse_start("busy_start");
    run_to_end("busy_start", 7, t);
    verify("busy_start", t);

    // Reset during the write of word 2
    load_rom(1'b1);
    pulse_start("midrst");
    t = 0;
    while (!(m_valid && m_wstrb == 4'b1111 && m_addr == DST + 32'd8) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_wr2", 32'(t < LIMIT), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    chk("midrst_writes_before", wa_q.size(), 2);
    clear_logs();
    reset = 1'b0;
    t = 0;
    while (!m_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_restart_delay", 32'(t), 1);
    chk("midrst_restart_addr", m_addr, SRC);
    chk("midrst_restart_words", 32'(words_done), 0);
    run_to_end("midrst", -1, t);
    verify("midrst", t);

    // Randomised rounds: latency, ready hold and image contents
    for (int r = 0; r < 8; r++) begin
      lat = $urandom_range(1, 5);
      hold_mode = 1'($urandom_range(0, 1));
      load_rom(($urandom_range(0, 2) != 0));
      pulse_start($sformatf("rnd%0d", r));
      run_to_end($sformatf("rnd%0d", r), -1, t);
      verify($sformatf("rnd%0d", r), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
